// File: rtl/cache_arbiter.sv
// Arbitrates the instruction and data caches onto one physical-memory port.
// One transaction in flight at a time; the response is routed back to the owner.
`timescale 1ns/1ps

module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       i_pmem_address,
    input  logic              i_pmem_read,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic [31:0]       d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic [31:0]       mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic last_grant_d;
    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic serving;

    assign serving = (state == SERVE_I) || (state == SERVE_D);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants are only issued from IDLE; ties go to whoever was not served last.
    always_comb begin
        i_req      = i_pmem_read;
        d_req      = d_pmem_read | d_pmem_write;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    if (RR_EN && last_grant_d) begin
                        grant_i = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
                end else if (i_req) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_i) begin
                    state_next = SERVE_I;
                end else if (grant_d) begin
                    state_next = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_next = RECOVER;
                end
            end
            RECOVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A simultaneous dcache read and write is issued as a write only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_address  <= 32'd0;
            mem_wdata    <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            last_grant_d <= 1'b1;
        end else if (grant_i) begin
            mem_address <= i_pmem_address;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
        end else if (grant_d) begin
            mem_address <= d_pmem_address;
            mem_wdata   <= d_pmem_wdata;
            mem_read    <= ~d_pmem_write;
            mem_write   <= d_pmem_write;
        end else if (serving && mem_resp) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            last_grant_d <= (state == SERVE_D);
        end
    end

    assign i_pmem_resp  = (state == SERVE_I) && mem_resp;
    assign d_pmem_resp  = (state == SERVE_D) && mem_resp;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a memory model checks issued requests,
// and a monitor checks every cache response against the expected queue.
`timescale 1ns/1ps

module tb_cache_arbiter;

    localparam int LINE_W = 256;

    logic              clk;
    logic              rst;
    logic [31:0]       i_pmem_address;
    logic              i_pmem_read;
    logic [31:0]       d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    // Outputs of the round-robin and fixed-priority instances
    logic [LINE_W-1:0] r_i_rdata, r_d_rdata, r_mem_wdata;
    logic [LINE_W-1:0] f_i_rdata, f_d_rdata, f_mem_wdata;
    logic              r_i_resp, r_d_resp, r_mem_read, r_mem_write;
    logic              f_i_resp, f_d_resp, f_mem_read, f_mem_write;
    logic [31:0]       r_mem_address, f_mem_address;

    // Observed outputs: whichever instance the current test targets
    logic              use_fixed;
    logic [LINE_W-1:0] i_pmem_rdata, d_pmem_rdata, mem_wdata;
    logic              i_pmem_resp, d_pmem_resp, mem_read, mem_write;
    logic [31:0]       mem_address;

    assign i_pmem_rdata = use_fixed ? f_i_rdata     : r_i_rdata;
    assign d_pmem_rdata = use_fixed ? f_d_rdata     : r_d_rdata;
    assign i_pmem_resp  = use_fixed ? f_i_resp      : r_i_resp;
    assign d_pmem_resp  = use_fixed ? f_d_resp      : r_d_resp;
    assign mem_address  = use_fixed ? f_mem_address : r_mem_address;
    assign mem_wdata    = use_fixed ? f_mem_wdata   : r_mem_wdata;
    assign mem_read     = use_fixed ? f_mem_read    : r_mem_read;
    assign mem_write    = use_fixed ? f_mem_write   : r_mem_write;

    cache_arbiter #(.LINE_W(LINE_W), .RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
        .i_pmem_rdata(r_i_rdata), .i_pmem_resp(r_i_resp),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_rdata(r_d_rdata), .d_pmem_resp(r_d_resp),
        .mem_address(r_mem_address), .mem_wdata(r_mem_wdata),
        .mem_read(r_mem_read), .mem_write(r_mem_write),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    cache_arbiter #(.LINE_W(LINE_W), .RR_EN(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
        .i_pmem_rdata(f_i_rdata), .i_pmem_resp(f_i_resp),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_rdata(f_d_rdata), .d_pmem_resp(f_d_resp),
        .mem_address(f_mem_address), .mem_wdata(f_mem_wdata),
        .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0]       addr;
        logic              write;
        logic [LINE_W-1:0] wdata;
        logic [LINE_W-1:0] rdata;
        int                lat;
    } mem_txn_t;

    typedef struct {
        logic              owner_d;
        logic [LINE_W-1:0] rdata;
    } resp_t;

    mem_txn_t mem_q[$];
    resp_t    resp_q[$];
    int       checks = 0;
    int       errors = 0;
    logic     manual_mem;
    logic     mem_busy;

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Transactions are expected in grant order, so one push fills both queues
    task automatic expectTxn(input logic owner_d, input logic [31:0] addr, input logic write,
                             input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] rdata,
                             input int lat);
        mem_txn_t t;
        resp_t    r;
        t.addr = addr; t.write = write; t.wdata = wdata; t.rdata = rdata; t.lat = lat;
        r.owner_d = owner_d; r.rdata = rdata;
        mem_q.push_back(t);
        resp_q.push_back(r);
    endtask

    task automatic applyStimulus(input logic i_rd, input logic [31:0] i_addr,
                                 input logic d_rd, input logic d_wr, input logic [31:0] d_addr,
                                 input logic [LINE_W-1:0] d_wd);
        i_pmem_read    = i_rd;
        i_pmem_address = i_addr;
        d_pmem_read    = d_rd;
        d_pmem_write   = d_wr;
        d_pmem_address = d_addr;
        d_pmem_wdata   = d_wd;
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Each cache drops its request the cycle after it sees its response
    task automatic runUntilIdle(input int budget);
        logic drop_i;
        logic drop_d;
        logic done;
        drop_i = 1'b0;
        drop_d = 1'b0;
        done   = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (i_pmem_resp) drop_i = 1'b1;
            if (d_pmem_resp) drop_d = 1'b1;
            @(posedge clk);
            #1;
            if (drop_i) i_pmem_read = 1'b0;
            if (drop_d) begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end
            if (!i_pmem_read && !d_pmem_read && !d_pmem_write && !mem_busy &&
                mem_q.size() == 0 && resp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL timeout: got %0d pending mem, %0d pending resp, expected 0",
                     mem_q.size(), resp_q.size());
            mem_q.delete();
            resp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Memory model: checks each new request and holds it until its latency expires
    initial begin
        mem_txn_t cur;
        int       cnt;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        mem_busy  = 1'b0;
        cnt       = 0;
        cur.addr = 32'd0; cur.write = 1'b0; cur.wdata = '0; cur.rdata = '0; cur.lat = 0;
        forever begin
            @(posedge clk);
            #1;
            if (manual_mem) begin
                mem_busy = 1'b0;
                continue;
            end
            mem_resp = 1'b0;
            if (mem_read || mem_write) begin
                checkOutput("strobe_exclusive", {255'd0, mem_read && mem_write}, '0);
            end
            if (!mem_busy) begin
                if (mem_read || mem_write) begin
                    if (mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_mem_request: got addr %0h, expected none",
                                 mem_address);
                    end else begin
                        cur      = mem_q.pop_front();
                        cnt      = cur.lat;
                        mem_busy = 1'b1;
                        checkOutput("mem_address", {224'd0, mem_address}, {224'd0, cur.addr});
                        checkOutput("mem_op", {254'd0, mem_read, mem_write},
                                    {254'd0, !cur.write, cur.write});
                        if (cur.write) checkOutput("mem_wdata", mem_wdata, cur.wdata);
                    end
                end
            end else begin
                checkOutput("mem_address_hold", {224'd0, mem_address}, {224'd0, cur.addr});
                checkOutput("mem_op_hold", {254'd0, mem_read, mem_write},
                            {254'd0, !cur.write, cur.write});
                cnt--;
                if (cnt <= 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = cur.rdata;
                    mem_busy  = 1'b0;
                end
            end
        end
    end

    // Response monitor: any response pulse must match the head of the queue
    initial begin
        resp_t exp_r;
        forever begin
            @(negedge clk);
            if (i_pmem_resp || d_pmem_resp) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp: got i=%0b d=%0b, expected none",
                             i_pmem_resp, d_pmem_resp);
                end else begin
                    exp_r = resp_q.pop_front();
                    checkOutput("i_pmem_resp", {255'd0, i_pmem_resp}, {255'd0, !exp_r.owner_d});
                    checkOutput("d_pmem_resp", {255'd0, d_pmem_resp}, {255'd0, exp_r.owner_d});
                    checkOutput("resp_rdata", exp_r.owner_d ? d_pmem_rdata : i_pmem_rdata,
                                exp_r.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [LINE_W-1:0] line_a, line_1, line_2, line_3, line_4, wd_5, wd_6;
        line_a = {8{32'hAAAA_AAAA}};
        line_1 = {8{32'h1111_1111}};
        line_2 = {8{32'h2222_2222}};
        line_3 = {8{32'h3333_3333}};
        line_4 = {8{32'h4444_4444}};
        wd_5   = {8{32'h5555_5555}};
        wd_6   = {8{32'h6666_6666}};
        use_fixed  = 1'b0;
        manual_mem = 1'b0;
        rst        = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, '0);

        // Outputs while held in reset
        @(posedge clk);
        #1;
        checkOutput("rst_mem_read", {255'd0, mem_read}, '0);
        checkOutput("rst_mem_write", {255'd0, mem_write}, '0);
        checkOutput("rst_mem_address", {224'd0, mem_address}, '0);
        checkOutput("rst_mem_wdata", mem_wdata, '0);
        checkOutput("rst_resps", {254'd0, i_pmem_resp, d_pmem_resp}, '0);
        doReset();

        $display("[TB] single icache read");
        expectTxn(1'b0, 32'h0000_0040, 1'b0, '0, line_a, 5);
        applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'd0, '0);
        @(posedge clk);
        #1;
        checkOutput("grant_latency", {255'd0, mem_read}, {255'd0, 1'b1});
        runUntilIdle(60);

        $display("[TB] round-robin ties");
        doReset();
        expectTxn(1'b0, 32'h0000_0100, 1'b0, '0, line_1, 3);
        expectTxn(1'b1, 32'h0000_0200, 1'b1, wd_5, line_2, 4);
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0200, wd_5);
        runUntilIdle(80);
        expectTxn(1'b0, 32'h0000_0180, 1'b0, '0, line_3, 2);
        expectTxn(1'b1, 32'h0000_0280, 1'b1, wd_6, line_4, 2);
        applyStimulus(1'b1, 32'h0000_0180, 1'b0, 1'b1, 32'h0000_0280, wd_6);
        runUntilIdle(80);

        $display("[TB] fixed-priority ties");
        use_fixed = 1'b1;
        doReset();
        expectTxn(1'b1, 32'h0000_0200, 1'b1, wd_5, line_2, 3);
        expectTxn(1'b0, 32'h0000_0100, 1'b0, '0, line_1, 3);
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0200, wd_5);
        runUntilIdle(80);
        expectTxn(1'b1, 32'h0000_0280, 1'b1, wd_6, line_4, 2);
        expectTxn(1'b0, 32'h0000_0180, 1'b0, '0, line_3, 2);
        applyStimulus(1'b1, 32'h0000_0180, 1'b0, 1'b1, 32'h0000_0280, wd_6);
        runUntilIdle(80);

        $display("[TB] dcache read and write together");
        expectTxn(1'b1, 32'h0000_0300, 1'b1, wd_6, line_3, 2);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0300, wd_6);
        runUntilIdle(60);

        $display("[TB] address change mid-transaction");
        expectTxn(1'b1, 32'h0000_0400, 1'b0, '0, line_4, 6);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0400, '0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        d_pmem_address = 32'h0000_0500;
        @(posedge clk);
        #1;
        checkOutput("addr_stable", {224'd0, mem_address}, {224'd0, 32'h0000_0400});
        runUntilIdle(60);

        $display("[TB] reset during transaction");
        manual_mem = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0600, wd_5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_write", {255'd0, mem_write}, {255'd0, 1'b1});
        rst = 1'b0;
        d_pmem_write = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_mem_op", {254'd0, mem_read, mem_write}, '0);
        checkOutput("abort_mem_address", {224'd0, mem_address}, '0);
        checkOutput("abort_mem_wdata", mem_wdata, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mem_rdata = line_1;
        mem_resp  = 1'b1;
        #1;
        checkOutput("stray_resp", {254'd0, i_pmem_resp, d_pmem_resp}, '0);
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        checkOutput("idle_after_stray", {254'd0, mem_read, mem_write}, '0);
        manual_mem = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
